// File: rtl/wb_regfile_flags.sv
// Writeback stage: one-entry writeback register, 16 x DW register file with R0 tied
// to zero, two bypassed combinational read ports, and Z/V/N flags updated on commit.
module wb_regfile_flags #(
  parameter int DW   = 16,
  parameter int NREG = 16,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_vld,
  input  logic [3:0]    ex_op,
  input  logic [AW-1:0] ex_rd,
  input  logic          ex_wen,
  input  logic [DW-1:0] ex_result,
  input  logic          ex_ovfl,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic [DW-1:0] rd_data1,
  output logic [DW-1:0] rd_data2,
  output logic          flag_z,
  output logic          flag_v,
  output logic          flag_n
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  logic          wb_vld;
  logic [3:0]    wb_op;
  logic [AW-1:0] wb_rd;
  logic          wb_wen;
  logic [DW-1:0] wb_data;
  logic          wb_ovfl;
  logic [DW-1:0] regs [NREG];

  logic wb_live;
  logic wb_commit;

  assign wb_live   = wb_vld & wb_wen;
  assign wb_commit = wb_live & (wb_rd != '0);

  // Stage 1: capture the execute result into the writeback entry
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_vld <= 1'b0;
    end else begin
      wb_vld <= ex_vld;
    end
    wb_op   <= ex_op;
    wb_rd   <= ex_rd;
    wb_wen  <= ex_wen;
    wb_data <= ex_result;
    wb_ovfl <= ex_ovfl;
  end

  // Stage 2: commit the pending entry to the array and the flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_commit) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
    end else if (wb_vld) begin
      case (wb_op)
        OP_ADD, OP_SUB: begin
          flag_z <= (wb_data == '0);
          flag_n <= wb_data[DW-1];
          flag_v <= wb_ovfl;
        end
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
          flag_z <= (wb_data == '0);
        end
        default: begin
        end
      endcase
    end
  end

  // R0 check last so a pending write to R0 can never leak through the bypass
  always_comb begin
    rd_data1 = regs[rd_addr1];
    if (wb_live && (wb_rd == rd_addr1)) rd_data1 = wb_data;
    if (rd_addr1 == '0) rd_data1 = '0;
  end

  always_comb begin
    rd_data2 = regs[rd_addr2];
    if (wb_live && (wb_rd == rd_addr2)) rd_data2 = wb_data;
    if (rd_addr2 == '0) rd_data2 = '0;
  end

endmodule

// File: tb/tb_wb_regfile_flags.sv
// Directed bench for wb_regfile_flags: hand-computed register and flag expectations.
module tb_wb_regfile_flags;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_vld;
  logic [3:0]  ex_op;
  logic [3:0]  ex_rd;
  logic        ex_wen;
  logic [15:0] ex_result;
  logic        ex_ovfl;
  logic [3:0]  rd_addr1;
  logic [3:0]  rd_addr2;
  logic [15:0] rd_data1;
  logic [15:0] rd_data2;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;

  int total = 0;
  int bad   = 0;

  wb_regfile_flags #(.DW(16), .NREG(16)) dut (
    .clk(clk), .rst(rst),
    .ex_vld(ex_vld), .ex_op(ex_op), .ex_rd(ex_rd), .ex_wen(ex_wen),
    .ex_result(ex_result), .ex_ovfl(ex_ovfl),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Step one clock; inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic wen,
                       input logic [15:0] res, input logic ovfl);
    ex_vld = 1'b1; ex_op = op; ex_rd = rd; ex_wen = wen; ex_result = res; ex_ovfl = ovfl;
    tick();
    ex_vld = 1'b0;
  endtask

  task automatic idle();
    ex_vld = 1'b0;
    tick();
  endtask

  task automatic rd1(input string tag, input logic [3:0] a, input logic [15:0] exp);
    rd_addr1 = a;
    #1;
    chk(tag, {16'h0, rd_data1}, {16'h0, exp});
  endtask

  task automatic rd_both(input string tag, input logic [3:0] a, input logic [15:0] exp);
    rd_addr1 = a;
    rd_addr2 = a;
    #1;
    chk({tag, "_p1"}, {16'h0, rd_data1}, {16'h0, exp});
    chk({tag, "_p2"}, {16'h0, rd_data2}, {16'h0, exp});
  endtask

  // Flags packed as {Z,V,N}
  task automatic chk_flags(input string tag, input logic [2:0] exp);
    chk(tag, {29'h0, flag_z, flag_v, flag_n}, {29'h0, exp});
  endtask

  initial begin
    rst = 1'b1; ex_vld = 1'b0; ex_op = 4'h0; ex_rd = 4'h0; ex_wen = 1'b0;
    ex_result = 16'h0; ex_ovfl = 1'b0; rd_addr1 = 4'h0; rd_addr2 = 4'h0;
    tick(); tick();
    rst = 1'b0;

    // Arbitrary writes, then a 2-cycle reset must wipe them
    issue(4'b0000, 4'd1, 1'b1, 16'hABCD, 1'b1);
    issue(4'b0000, 4'd9, 1'b1, 16'h8001, 1'b1);
    idle();
    rd1("pre_rst_r1", 4'd1, 16'hABCD);
    chk_flags("pre_rst_flags", 3'b011);
    issue(4'b0000, 4'd12, 1'b1, 16'h5555, 1'b0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int a = 0; a < 16; a++) rd_both($sformatf("rst_r%0d", a), 4'(a), 16'h0000);
    chk_flags("rst_flags", 3'b000);

    // ADD with saturated overflow result: bypass first, then array and flags
    issue(4'b0000, 4'd3, 1'b1, 16'h8000, 1'b1);
    rd1("add_bypass", 4'd3, 16'h8000);
    chk_flags("add_flags_before_commit", 3'b000);
    idle();
    rd1("add_array", 4'd3, 16'h8000);
    chk_flags("add_flags", 3'b111 & 3'b011 | 3'b001);

    // XOR zero result: Z set, V and N hold
    issue(4'b0010, 4'd5, 1'b1, 16'h0000, 1'b0);
    idle();
    rd1("xor_r5", 4'd5, 16'h0000);
    chk_flags("xor_flags", 3'b111);

    // PADDSB then RED: registers written, flags untouched
    issue(4'b0111, 4'd2, 1'b1, 16'h7F7F, 1'b0);
    issue(4'b0011, 4'd4, 1'b1, 16'h01FE, 1'b0);
    idle();
    rd1("paddsb_r2", 4'd2, 16'h7F7F);
    rd1("red_r4", 4'd4, 16'h01FE);
    chk_flags("noflag_ops", 3'b111);

    // SUB into R0: R0 stays zero even while pending; flags still update
    issue(4'b0001, 4'd0, 1'b1, 16'h0000, 1'b0);
    rd_both("r0_pending", 4'd0, 16'h0000);
    idle();
    rd_both("r0_after", 4'd0, 16'h0000);
    chk_flags("sub_r0_flags", 3'b100);

    // Back-to-back writes to R7 seen on both ports without a stale value
    rd_both("r7_init", 4'd7, 16'h0000);
    issue(4'b0010, 4'd7, 1'b1, 16'h1111, 1'b0);
    rd_both("r7_first", 4'd7, 16'h1111);
    issue(4'b0010, 4'd7, 1'b1, 16'h2222, 1'b0);
    rd_both("r7_second", 4'd7, 16'h2222);
    idle();
    rd_both("r7_array", 4'd7, 16'h2222);
    chk_flags("r7_flags", 3'b000);

    // wen=0 updates flags but not the register; ex_vld=0 changes nothing
    issue(4'b0100, 4'd8, 1'b0, 16'h0000, 1'b0);
    rd1("nowen_bypass", 4'd8, 16'h0000);
    idle();
    rd1("nowen_r8", 4'd8, 16'h0000);
    chk_flags("nowen_flags", 3'b100);
    ex_vld = 1'b0; ex_op = 4'b0000; ex_rd = 4'd8; ex_wen = 1'b1;
    ex_result = 16'hBEEF; ex_ovfl = 1'b1;
    tick(); tick();
    rd1("novld_r8", 4'd8, 16'h0000);
    chk_flags("novld_flags", 3'b100);

    // Opcode 1xxx holds all flags
    issue(4'b1000, 4'd10, 1'b1, 16'hF00F, 1'b1);
    idle();
    rd1("op1xxx_r10", 4'd10, 16'hF00F);
    chk_flags("op1xxx_flags", 3'b100);

    // Reset on the edge right after capture discards the pending entry
    issue(4'b0000, 4'd6, 1'b1, 16'h0001, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd1("midrst_r6", 4'd6, 16'h0000);
    chk_flags("midrst_flags", 3'b000);
    idle();
    rd1("midrst_r6_later", 4'd6, 16'h0000);
    chk_flags("midrst_flags_later", 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile_flags.md
# wb_regfile_flags

Writeback stage directly downstream of the execute-stage compute units (16-bit saturating add/sub, PADDSB, RED, shifter, XOR). It captures each execute result into a one-entry writeback register, commits it to a 16 x 16-bit register file one cycle later, and updates the Z/V/N flag register under opcode-dependent rules. It also supplies two combinational read ports, with bypass from the pending writeback entry, to the decode stage.

## Interface
Parameters:
- DW, 16, data width of a register.
- NREG, 16, number of registers; address width is log2(NREG) = 4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_vld  in  1  execute result valid this cycle.
- ex_op  in  4  opcode of the executing instruction.
- ex_rd  in  4  destination register.
- ex_wen  in  1  instruction writes a register.
- ex_result  in  DW  result from the execute stage, already saturated where applicable.
- ex_ovfl  in  1  Error/overflow output of the add/sub unit.
- rd_addr1  in  4  read port 1 address.
- rd_addr2  in  4  read port 2 address.
- rd_data1  out  DW  read port 1 data (combinational).
- rd_data2  out  DW  read port 2 data (combinational).
- flag_z  out  1  zero flag (registered).
- flag_v  out  1  overflow flag (registered).
- flag_n  out  1  negative flag (registered).

## Operation
- Writeback register: on every edge it captures {ex_vld, ex_op, ex_rd, ex_wen, ex_result, ex_ovfl} as {wb_vld, wb_op, wb_rd, wb_wen, wb_data, wb_ovfl}.
- Commit: on the edge after capture, if wb_vld & wb_wen & (wb_rd != 0), regs[wb_rd] <= wb_data.
- R0 is hardwired to zero:
  - Writes to R0 are dropped.
  - Reads of R0 return 0, including when a write to R0 is pending.
- Read path, per port, in priority order:
  - addr == 0 returns 0.
  - Otherwise, if wb_vld & wb_wen & (wb_rd == addr), return wb_data (bypass).
  - Otherwise return regs[addr].
  - Writeback applies the same bypass on both ports at once.
- Flag update happens on the commit edge when wb_vld = 1. It is independent of wb_wen and wb_rd.
  - 0000 ADD, 0001 SUB: Z = (wb_data == 0), N = wb_data[15], V = wb_ovfl.
  - 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR: Z = (wb_data == 0). N and V hold.
  - 0011 RED, 0111 PADDSB, 1xxx: all flags hold.
- wb_vld = 0: no register write and no flag change.
- Z is computed on the saturated value as delivered. Example: a saturated 16'h8000 gives Z = 0.

## Timing
- Reset (rst high at an edge):
  - All 16 registers = 0.
  - flag_z, flag_v, flag_n = 0.
  - wb_vld = 0.
  - rd_data1/rd_data2 therefore read 0 for every address after reset.
- rst has priority over everything. A pending writeback entry present at a reset edge is discarded: no register write, no flag update.
- Latency:
  - ex_* is sampled at edge k.
  - The value is visible on read ports via bypass from just after edge k.
  - It is in the array, and flags reflect it, from just after edge k+1.
- Back-to-back writes to the same register: at edge k+1 the array takes the older value and wb_* takes the newer one. Reads return the newer value (bypass) and never a stale one.
- A write at edge k+1 and a bypass lookup of a new entry are concurrent and do not conflict.
- Flag outputs change only at clock edges. There is no combinational path from ex_* to the flags.
- Read ports are combinational from rd_addr*, the wb_* registers, and the array.

## Test plan
- Reset: hold rst for 2 cycles after arbitrary writes. Then every address on both ports reads 16'h0000 and the flags read Z=0, V=0, N=0.
- ADD overflow: ex_vld=1, op=0000, rd=3, wen=1, result=16'h8000, ovfl=1.
  - One cycle later, rd_data1 (addr 3) = 16'h8000 via bypass.
  - After the next edge, the array holds 16'h8000 and flags are Z=0, N=1, V=1.
- XOR zero following the ADD above: op=0010, rd=5, result=16'h0000. After commit, Z=1 while N=1 and V=1 hold.
- No-flag ops: PADDSB (op=0111, rd=2, result=16'h7F7F), then RED (op=0011, rd=4, result=16'h01FE).
  - R2 = 16'h7F7F and R4 = 16'h01FE.
  - Flags are unchanged from the prior state.
- R0 and bypass priority:
  - SUB with rd=0, wen=1, result=16'h0000: R0 still reads 0 and Z=1.
  - Back-to-back writes R7=16'h1111 then R7=16'h2222, with both ports on addr 7: they read 1111 and then 2222, never 0 in between.
- Reset mid-operation: issue ADD, rd=6, result=16'h0001, then assert rst on the very next edge. R6 stays 16'h0000 and the flags are 000.
